// File: rtl/datapath_sequencer.sv
// datapath_sequencer: control unit that sequences LOAD/ADD/MULADD/NOP into accumulator load cycles.
// Define SEQ_SATURATE_EN to clamp add results at all ones instead of wrapping.
module datapath_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] operand,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] ac_in,
   output logic [WIDTH-1:0] ABus,
   output logic             SelB,
   output logic             LoadAC,
   output logic             AddAlu,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SETTLE, S_DONE} state_t;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_MULADD = 2'b11;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] abus_q, abus_d;
   logic             selb_q, selb_d;
   logic             loadac_q, loadac_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;

   logic             enter_exec;
   logic             cur_carry;
   logic [1:0]       exec_op;
   logic [WIDTH-1:0] exec_operand;

   // Carry of the add happening on the datapath in the current EXEC cycle.
   assign cur_carry = ({1'b0, ac_in} + {1'b0, operand_q}) > {1'b0, {WIDTH{1'b1}}};

   // Instruction that will drive the next EXEC cycle: fresh inputs on accept, latched copy otherwise.
   assign exec_op      = (state_q == S_IDLE) ? opcode  : op_q;
   assign exec_operand = (state_q == S_IDLE) ? operand : operand_q;

`ifdef SEQ_SATURATE_EN
   logic [WIDTH-1:0] next_ac;
   logic             pred_carry;

   // AC value the next EXEC cycle will see, predicted from this cycle's load so outputs stay registered.
   always_comb begin
      next_ac = ac_in;
      if (loadac_q) begin
         next_ac = selb_q ? ac_in + abus_q : abus_q;
      end
   end

   assign pred_carry = ({1'b0, next_ac} + {1'b0, exec_operand}) > {1'b0, {WIDTH{1'b1}}};
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      operand_d  = operand_q;
      rem_d      = rem_q;
      abus_d     = '0;
      selb_d     = 1'b0;
      loadac_d   = 1'b0;
      done_d     = 1'b0;
      result_d   = result_q;
      overflow_d = overflow_q;
      enter_exec = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d       = opcode;
               operand_d  = operand;
               rem_d      = count;
               overflow_d = 1'b0;
               if (opcode == OP_NOP) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (opcode == OP_MULADD && count == '0) begin
                  state_d = S_SETTLE;
               end else begin
                  state_d    = S_EXEC;
                  enter_exec = 1'b1;
               end
            end
         end
         S_EXEC: begin
            if (op_q != OP_LOAD) begin
               overflow_d = overflow_q | cur_carry;
            end
            if (op_q == OP_MULADD && rem_q != CNT_W'(1)) begin
               rem_d      = rem_q - CNT_W'(1);
               enter_exec = 1'b1;
            end else begin
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            result_d = ac_in;
            state_d  = S_DONE;
            done_d   = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (enter_exec) begin
         loadac_d = 1'b1;
         abus_d   = exec_operand;
         selb_d   = (exec_op != OP_LOAD);
`ifdef SEQ_SATURATE_EN
         if (selb_d && pred_carry) begin
            selb_d = 1'b0;
            abus_d = {WIDTH{1'b1}};
         end
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_NOP;
         operand_q  <= '0;
         rem_q      <= '0;
         abus_q     <= '0;
         selb_q     <= 1'b0;
         loadac_q   <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         operand_q  <= operand_d;
         rem_q      <= rem_d;
         abus_q     <= abus_d;
         selb_q     <= selb_d;
         loadac_q   <= loadac_d;
         done_q     <= done_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign ABus        = abus_q;
   assign SelB        = selb_q;
   assign AddAlu      = selb_q;
   assign LoadAC      = loadac_q;
   assign done        = done_q;
   assign result      = result_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: scoreboard bench with a behavioural accumulator datapath on ac_in.
// Honors SEQ_SATURATE_EN to select the saturating expectations.
module tb_datapath_sequencer;

`ifdef SEQ_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [1:0] opcode = 2'b00;
   logic [3:0] operand = 4'd0;
   logic [3:0] count = 4'd0;
   logic [3:0] ac = 4'd0;
   logic [3:0] ABus;
   logic       SelB, LoadAC, AddAlu, done, overflow;
   logic [3:0] result;

   typedef struct {
      logic [1:0] op;
      logic [3:0] opnd;
      logic [3:0] res;
      bit         ovf;
      int         lat;
      int         loads;
      int         acc;
   } exp_t;

   exp_t       sb[$];
   exp_t       cur;
   logic [4:0] ms;
   logic       want_selb;
   logic [3:0] want_abus;
   logic [3:0] model_ac = 4'd0;
   logic [3:0] model_res = 4'd0;
   int         checks = 0;
   int         errors = 0;
   int         cycle_ctr = 0;
   int         load_cnt = 0;
   int         n_acc = 0;
   int         issued = 0;

   datapath_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
      .clock(clock), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .operand(operand), .count(count),
      .ac_in(ac), .ABus(ABus), .SelB(SelB), .LoadAC(LoadAC), .AddAlu(AddAlu),
      .done(done), .result(result), .overflow(overflow)
   );

   always #5 clock = ~clock;

   // Accumulator datapath: AC <= SelB ? AC + ABus : ABus when LoadAC.
   always @(posedge clock) begin
      if (LoadAC) ac <= SelB ? ac + ABus : ABus;
   end

   always @(posedge clock) begin
      cycle_ctr <= cycle_ctr + 1;
      if (!reset && instr_valid && instr_ready) n_acc <= n_acc + 1;
   end

   task automatic check(input string tag, input int act, input int want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, want);
      end
   endtask

   function automatic logic [3:0] add_step(input logic [3:0] a, input logic [3:0] b, inout bit ovf);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[4]) ovf = 1'b1;
      return (SAT && s[4]) ? 4'hF : s[3:0];
   endfunction

   task automatic issue(input logic [1:0] op, input logic [3:0] opnd, input logic [3:0] cnt, input bit hold);
      exp_t x;
      int   waited;
      @(negedge clock);
      instr_valid = 1'b1;
      opcode  = op;
      operand = opnd;
      count   = cnt;
      waited  = 0;
      while (!instr_ready && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      if (!instr_ready) begin
         check("accept_timeout", 0, 1);
         instr_valid = 1'b0;
         return;
      end
      x.op = op; x.opnd = opnd; x.ovf = 1'b0; x.loads = 0;
      case (op)
         2'b00: begin x.lat = 1; end
         2'b01: begin model_ac = opnd; x.lat = 3; x.loads = 1; end
         2'b10: begin model_ac = add_step(model_ac, opnd, x.ovf); x.lat = 3; x.loads = 1; end
         default: begin
            for (int i = 0; i < int'(cnt); i++) model_ac = add_step(model_ac, opnd, x.ovf);
            x.lat = 2 + int'(cnt);
            x.loads = int'(cnt);
         end
      endcase
      if (op != 2'b00) model_res = model_ac;
      x.res = model_res;
      @(posedge clock);
      #1;
      x.acc = cycle_ctr;
      sb.push_back(x);
      issued++;
      if (!hold) instr_valid = 1'b0;
      opcode  = ~op;
      operand = ~opnd;
      count   = ~cnt;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clock);
      check("ready_idle", instr_ready, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, instr_ready, 1);
      check({tag, "_abus"}, ABus, 0);
      check({tag, "_selb"}, SelB, 0);
      check({tag, "_loadac"}, LoadAC, 0);
      check({tag, "_addalu"}, AddAlu, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_ovf"}, overflow, 0);
   endtask

   // Monitor: checks each load cycle against the AC model and pops one entry per done pulse.
   always @(negedge clock) begin
      if (!reset) begin
         if (LoadAC) begin
            if (sb.size() == 0) begin
               check("load_without_instr", 1, 0);
            end else begin
               cur = sb[0];
               want_selb = (cur.op != 2'b01);
               want_abus = cur.opnd;
               ms = {1'b0, ac} + {1'b0, cur.opnd};
               if (SAT && want_selb && ms[4]) begin
                  want_selb = 1'b0;
                  want_abus = 4'hF;
               end
               check("abus", ABus, want_abus);
               check("selb", SelB, want_selb);
               check("addalu", AddAlu, want_selb);
               load_cnt++;
            end
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               cur = sb.pop_front();
               $display("txn op=%0d operand=%0d result=%0d ovf=%0d latency=%0d loads=%0d",
                        cur.op, cur.opnd, result, overflow, cycle_ctr - cur.acc + 1, load_cnt);
               check("result", result, cur.res);
               check("overflow", overflow, cur.ovf);
               check("latency", cycle_ctr - cur.acc + 1, cur.lat);
               check("load_count", load_cnt, cur.loads);
               check("ready_in_done", instr_ready, 0);
            end
            load_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;

      issue(2'b01, 4'd5, 4'd0, 1'b0);
      wait_idle();

      issue(2'b01, 4'd3, 4'd0, 1'b0);
      issue(2'b10, 4'd4, 4'd0, 1'b0);
      wait_idle();

      issue(2'b01, 4'd0, 4'd0, 1'b0);
      issue(2'b11, 4'd3, 4'd4, 1'b0);
      wait_idle();

      issue(2'b01, 4'd9, 4'd0, 1'b0);
      issue(2'b10, 4'd9, 4'd0, 1'b0);
      wait_idle();

      issue(2'b11, 4'd5, 4'd0, 1'b1);
      issue(2'b00, 4'd7, 4'd3, 1'b0);
      wait_idle();

      issue(2'b01, 4'd1, 4'd0, 1'b0);
      issue(2'b11, 4'd7, 4'd3, 1'b0);
      wait_idle();

      issue(2'b01, 4'd2, 4'd0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)), 1'b0);
      end
      wait_idle();

      issue(2'b01, 4'd1, 4'd0, 1'b0);
      wait_idle();
      issue(2'b11, 4'd2, 4'd5, 1'b0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      sb.delete();
      load_cnt = 0;
      model_res = 4'd0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      issue(2'b01, 4'd6, 4'd0, 1'b0);
      wait_idle();

      check("accept_count", n_acc, issued);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control unit for the 4-bit accumulator datapath. Drives ABus, SelB, LoadAC and AddAlu, and reads back OutBus.
- Accepts one instruction at a time over a valid/ready handshake and sequences it into one or more accumulator load cycles.
- Returns the final accumulator value with a one-cycle done pulse and a sticky overflow flag.
- Sits between the instruction source and the datapath, and is the only driver of the datapath control inputs.

Parameters:
- WIDTH, 4, datapath width; must match the ABus/OutBus width.
- CNT_W, 4, width of the repeat count for MULADD.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  sequencer can accept an instruction.
- opcode  input  2  00 NOP, 01 LOAD, 10 ADD, 11 MULADD.
- operand  input  WIDTH  operand value.
- count  input  CNT_W  repeat count; used by MULADD only.
- ac_in  input  WIDTH  datapath OutBus (current accumulator).
- ABus  output  WIDTH  operand bus to the datapath.
- SelB  output  1  0 selects ABus, 1 selects ABus+AC.
- LoadAC  output  1  accumulator load enable.
- AddAlu  output  1  add-operation indicator; equals SelB.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  accumulator value captured at completion.
- overflow  output  1  carry occurred during the last instruction.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - instr_ready=1; ABus, SelB, LoadAC, AddAlu, done, overflow and result all =0.
  - The datapath AC has no reset, so AC contents are undefined until a LOAD executes.
- Handshake:
  - An instruction is accepted when instr_valid & instr_ready at a rising edge.
  - opcode, operand and count are latched on acceptance; later input changes are ignored.
  - instr_ready=1 only in IDLE.
- States:
  - IDLE: on accept, go to EXEC, except NOP goes to DONE. Clear overflow on accept.
  - EXEC: drive ABus=latched operand for the whole state.
    - LOAD: SelB=0, LoadAC=1 for one cycle, then go to SETTLE.
    - ADD: SelB=1, LoadAC=1 for one cycle, then go to SETTLE.
    - MULADD: SelB=1, LoadAC=1 for N cycles, where N=latched count; remaining count decrements each cycle; go to SETTLE when remaining==1. If count==0, skip EXEC entirely (IDLE goes to SETTLE) and make no load.
  - SETTLE: LoadAC=0, SelB=0. Capture result<=ac_in. Go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE. instr_ready is 0 here and returns to 1 in IDLE.
- Latency, accept edge to done high:
  - LOAD/ADD: 3 cycles.
  - MULADD: 2+N cycles.
  - NOP: 1 cycle; result holds its previous value.
- Arithmetic:
  - For every EXEC cycle with SelB=1, form the sum {1'b0,ac_in}+{1'b0,operand} internally at WIDTH+1 bits.
  - If bit WIDTH is set, set overflow (sticky until the next accept).
  - The datapath wraps modulo 2^WIDTH.
- Outputs are registered; SelB/LoadAC/AddAlu/ABus are glitch-free, decoded from registered state.
- instr_valid in non-IDLE states is ignored; no instruction is lost because instr_ready=0.

Optional Feature:
- Macro: SEQ_SATURATE_EN.
- With the macro defined:
  - In an add EXEC cycle whose internal sum carries, drive SelB=0, AddAlu=0 and ABus=all ones, with LoadAC=1.
  - AC therefore saturates at 2^WIDTH-1.
  - Remaining MULADD iterations continue and stay saturated; overflow is still set.
- Without the macro: wrap-around only, overflow flag as above.

Test Plan:
- reset, then LOAD operand=5 -> LoadAC high exactly 1 cycle with SelB=0, ABus=5; done 3 cycles after accept; result=5; overflow=0.
- LOAD 3, then ADD 4 -> result=7, SelB=AddAlu=1 during the ADD EXEC cycle, overflow=0.
- LOAD 0, then MULADD operand=3 count=4 -> LoadAC high 4 consecutive cycles; result=12; done at accept+6.
- LOAD 9, then ADD 9 -> default build: result=2, overflow=1; with SEQ_SATURATE_EN: result=15, overflow=1.
- MULADD count=0, then NOP -> MULADD: no LoadAC pulse, result=current AC, done at accept+2; NOP: done at accept+1, result unchanged; instr_valid held high back-to-back accepted only when instr_ready=1.
- Assert reset during the 2nd cycle of MULADD count=5 -> all outputs 0 immediately (asynchronous), instr_ready=1; next LOAD 6 completes normally with result=6.
